// File: rtl/regfile_wb_sched.sv
// Writeback scheduler for the 32x32 register file: round-robin arbitration of NREQ
// result producers onto one registered write port, plus a busy scoreboard for issue.
module regfile_wb_sched #(
    parameter int NREQ = 3,
    parameter int XLEN = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue_valid,
    input  logic [4:0]             issue_rs1,
    input  logic [4:0]             issue_rs2,
    input  logic [4:0]             issue_rd,
    input  logic                   issue_wr,
    output logic                   issue_stall,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*5-1:0]      req_rd,
    input  logic [NREQ*XLEN-1:0]   req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic                   rf_we,
    output logic [4:0]             rf_rd,
    output logic [XLEN-1:0]        rf_wdata,
    output logic [31:0]            busy_mask,
    output logic                   err_spurious
);
    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [LW-1:0]   last_q, last_d;
    logic [31:0]     busy_q, busy_d;
    logic            rf_we_q, rf_we_d;
    logic [4:0]      rf_rd_q, rf_rd_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
    logic            err_q, err_d;

    logic [31:0]     busy_eff;
    logic [NREQ-1:0] grant_vec;
    logic [LW-1:0]   grant_idx;
    logic [LW-1:0]   cand;
    logic            transfer;
    logic            issue_fire;
    logic [4:0]      g_rd;
    logic [XLEN-1:0] g_data;

    // x0 is never tracked, so its bit reads as zero regardless of state.
    assign busy_eff = {busy_q[31:1], 1'b0};

    assign issue_stall = issue_valid & (rst | busy_eff[issue_rs1] | busy_eff[issue_rs2]
                                       | (issue_wr & busy_eff[issue_rd]));
    assign issue_fire  = issue_valid & ~issue_stall;

    // Round-robin: scan from last+1 upward, wrapping; first valid requester wins.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        grant_vec = '0;
        grant_idx = '0;
        cand      = '0;
        transfer  = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = LW'((int'(last_q) + k) % NREQ);
            if (!transfer && req_valid[cand]) begin
                transfer        = 1'b1;
                grant_idx       = cand;
                grant_vec[cand] = 1'b1;
            end
        end
        if (rst) begin
            grant_vec = '0;
            transfer  = 1'b0;
        end
    end

    assign req_ready = grant_vec;
    assign g_rd      = req_rd[5*int'(grant_idx) +: 5];
    assign g_data    = req_data[XLEN*int'(grant_idx) +: XLEN];

    always_comb begin
        last_d     = transfer ? grant_idx : last_q;
        rf_we_d    = transfer && (g_rd != 5'd0);
        rf_rd_d    = transfer ? g_rd : rf_rd_q;
        rf_wdata_d = transfer ? g_data : rf_wdata_q;
        err_d      = err_q | (transfer && (g_rd != 5'd0) && !busy_eff[g_rd]);

        // Clear first, then set: a same-edge set of the same register must win.
        busy_d = busy_q;
        if (rf_we_q)
            busy_d[rf_rd_q] = 1'b0;
        if (issue_fire && issue_wr && (issue_rd != 5'd0))
            busy_d[issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q     <= LW'(NREQ - 1);
            busy_q     <= '0;
            rf_we_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_wdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            last_q     <= last_d;
            busy_q     <= busy_d;
            rf_we_q    <= rf_we_d;
            rf_rd_q    <= rf_rd_d;
            rf_wdata_q <= rf_wdata_d;
            err_q      <= err_d;
        end
    end

    assign rf_we        = rf_we_q;
    assign rf_rd        = rf_rd_q;
    assign rf_wdata     = rf_wdata_q;
    assign busy_mask    = busy_q;
    assign err_spurious = err_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Self-checking bench for regfile_wb_sched: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural scoreboard model.
module tb_regfile_wb_sched;
    localparam int NREQ = 3;
    localparam int XLEN = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 issue_valid;
    logic [4:0]           issue_rs1, issue_rs2, issue_rd;
    logic                 issue_wr;
    logic                 issue_stall;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*5-1:0]    req_rd;
    logic [NREQ*XLEN-1:0] req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 rf_we;
    logic [4:0]           rf_rd;
    logic [XLEN-1:0]      rf_wdata;
    logic [31:0]          busy_mask;
    logic                 err_spurious;

    always #5 clk = ~clk;

    regfile_wb_sched #(.NREQ(NREQ), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rd(issue_rd), .issue_wr(issue_wr), .issue_stall(issue_stall),
        .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data), .req_ready(req_ready),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .busy_mask(busy_mask), .err_spurious(err_spurious)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    endtask

    // Behavioural model: a set of in-flight registers, the last winner, and the write stage.
    bit [31:0]       m_busy;
    int              m_last;
    bit              m_we;
    bit [4:0]        m_rd;
    bit [31:0]       m_wdata;
    bit              m_err;
    bit              m_valid = 1'b0;
    logic [NREQ-1:0] m_ready;

    function automatic int model_grant();
        if (rst) return -1;
        for (int k = 1; k <= NREQ; k++) begin
            int j = (m_last + k) % NREQ;
            if (req_valid[j]) return j;
        end
        return -1;
    endfunction

    function automatic bit model_stall();
        if (!issue_valid) return 1'b0;
        if (rst) return 1'b1;
        return m_busy[issue_rs1] | m_busy[issue_rs2] | (issue_wr & m_busy[issue_rd]);
    endfunction

    task automatic model_step();
        int        g;
        bit [31:0] nb;
        bit [4:0]  grd;
        if (rst) begin
            m_busy = '0; m_last = NREQ - 1; m_we = 0; m_rd = '0; m_wdata = '0; m_err = 0;
            m_valid = 1'b1;
            return;
        end
        g  = model_grant();
        nb = m_busy;
        if (m_we) nb[m_rd] = 1'b0;
        if (issue_valid && !model_stall() && issue_wr && issue_rd != 0) nb[issue_rd] = 1'b1;
        if (g >= 0) begin
            grd = req_rd[5*g +: 5];
            if (grd != 0 && !m_busy[grd]) m_err = 1'b1;
            m_we    = (grd != 0);
            m_rd    = grd;
            m_wdata = req_data[XLEN*g +: XLEN];
            m_last  = g;
        end else begin
            m_we = 1'b0;
        end
        m_busy = nb;
    endtask

    // Single compare point, half a cycle away from the active edge.
    task automatic sample();
        int g;
        @(negedge clk);
        g = model_grant();
        m_ready = (g >= 0) ? (NREQ'(1) << g) : '0;
        if (m_valid) begin
            check("ready",    32'(req_ready),    32'(m_ready));
            check("stall",    32'(issue_stall),  32'(model_stall()));
            check("rf_we",    32'(rf_we),        32'(m_we));
            check("rf_rd",    32'(rf_rd),        32'(m_rd));
            check("rf_wdata", rf_wdata,          m_wdata);
            check("busy",     busy_mask,         m_busy);
            check("err",      32'(err_spurious), 32'(m_err));
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        rst = 0; issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0; issue_wr = 0;
        req_valid = '0;
    endtask

    task automatic issue(input int rd_, input bit wr_, input int rs1_, input int rs2_);
        issue_valid = 1; issue_rd = 5'(rd_); issue_wr = wr_;
        issue_rs1 = 5'(rs1_); issue_rs2 = 5'(rs2_);
    endtask

    task automatic set_req(input int i, input int rd_, input logic [31:0] data_);
        req_valid[i] = 1'b1;
        req_rd[5*i +: 5] = 5'(rd_);
        req_data[XLEN*i +: XLEN] = data_;
    endtask

    bit        pend_v[NREQ];
    bit [4:0]  pend_rd[NREQ];
    bit [31:0] pend_data[NREQ];

    function automatic bit targeted(input bit [4:0] r);
        for (int j = 0; j < NREQ; j++) if (pend_v[j] && pend_rd[j] == r) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        idle();
        req_rd = '0; req_data = '0;
        rst = 1;

        // Reset with all requesters valid: nothing granted, stall mirrors issue_valid.
        for (int i = 0; i < NREQ; i++) set_req(i, 0, 32'h11 * (i + 1));
        for (int c = 0; c < 2; c++) begin
            issue_valid = (c == 1);
            sample();
            check("rst_ready", 32'(req_ready), 32'h0);
            check("rst_stall", 32'(issue_stall), 32'(c == 1));
            advance();
        end
        rst = 0; issue_valid = 0;
        sample();
        check("post_rst_busy", busy_mask, 32'h0);
        check("post_rst_we", 32'(rf_we), 32'h0);
        check("first_grant", 32'(req_ready), 32'h1);
        advance();
        idle();

        // Round-robin: fresh reset so requester 0 leads; x5/x6/x7 busy.
        rst = 1; sample(); advance(); rst = 0;
        for (int r = 5; r <= 7; r++) begin
            issue(r, 1, 0, 0);
            sample(); check("rr_issue_stall", 32'(issue_stall), 32'h0); advance();
        end
        idle();
        for (int i = 0; i < NREQ; i++) set_req(i, 5 + i, 32'hA000_0000 + i);
        for (int k = 0; k < 6; k++) begin
            issue_valid = 0;
            if (k >= 2 && k <= 4) issue(k + 3, 1, 0, 0);
            sample();
            check("rr_grant", 32'(req_ready), 32'(1 << (k % 3)));
            if (k >= 1) check("rr_we", 32'(rf_we), 32'h1);
            if (k >= 2 && k <= 4) check("rr_reissue_stall", 32'(issue_stall), 32'h0);
            advance();
            set_req(k % 3, 5 + k % 3, 32'hB000_0000 + k);
        end
        idle();
        sample(); check("rr_tail_we", 32'(rf_we), 32'h1); check("rr_tail_rd", 32'(rf_rd), 32'd7);
        advance();
        for (int c = 0; c < 3; c++) begin sample(); advance(); end
        sample(); check("rr_busy_drained", busy_mask, 32'h0); advance();

        // RAW: consumer of x10 stalls until the writeback has landed.
        issue(10, 1, 0, 0);
        sample(); check("raw_issue", 32'(issue_stall), 32'h0); advance();
        for (int c = 1; c <= 5; c++) begin
            issue(0, 0, 10, 0);
            if (c == 3) set_req(1, 10, 32'hDEAD_BEEF);
            if (c == 4) req_valid = '0;
            sample();
            check("raw_stall", 32'(issue_stall), 32'(c <= 4));
            if (c == 3) check("raw_grant", 32'(req_ready), 32'h2);
            if (c == 4) begin
                check("raw_we", 32'(rf_we), 32'h1);
                check("raw_rd", 32'(rf_rd), 32'd10);
                check("raw_data", rf_wdata, 32'hDEAD_BEEF);
            end
            advance();
        end
        idle();

        // WAW: second writer of x3 waits for the first write to complete.
        issue(3, 1, 0, 0);
        sample(); advance();
        for (int c = 1; c <= 4; c++) begin
            issue(3, 1, 0, 0);
            if (c == 2) set_req(2, 3, 32'h33);
            if (c == 3) req_valid = '0;
            sample();
            check("waw_stall", 32'(issue_stall), 32'(c <= 3));
            if (c == 2) check("waw_grant", 32'(req_ready), 32'h4);
            if (c == 3) check("waw_we_rd", 32'(rf_rd), 32'd3);
            advance();
        end
        idle();
        set_req(0, 3, 32'h44);
        sample(); check("waw_rebusy", busy_mask, 32'h8); check("waw_grant2", 32'(req_ready), 32'h1);
        advance(); idle();
        sample(); advance();
        sample(); check("waw_clear", busy_mask, 32'h0); advance();

        // x0: never tracked, write is consumed silently.
        issue(0, 1, 0, 0);
        sample(); check("x0_issue", 32'(issue_stall), 32'h0); advance();
        idle(); set_req(0, 0, 32'h1234);
        sample(); check("x0_busy", busy_mask, 32'h0); check("x0_grant", 32'(req_ready), 32'h1);
        advance(); idle();
        sample(); check("x0_we", 32'(rf_we), 32'h0); check("x0_err", 32'(err_spurious), 32'h0);
        advance();

        // Spurious write to idle x9, same-edge set/clear of x9, then mid-stream reset.
        set_req(0, 9, 32'h99);
        sample(); check("sp_grant", 32'(req_ready), 32'h1); advance();
        idle(); issue(9, 1, 0, 0);
        sample();
        check("sp_err", 32'(err_spurious), 32'h1);
        check("sp_we_rd", 32'(rf_rd), 32'd9);
        check("sp_issue", 32'(issue_stall), 32'h0);
        advance();
        issue(12, 1, 0, 0);
        sample(); check("set_wins", busy_mask, 32'h200); advance();
        idle(); rst = 1; set_req(1, 12, 32'hC);
        sample(); check("mid_rst_busy", busy_mask, 32'h1200); check("mid_rst_ready", 32'(req_ready), 32'h0);
        advance();
        idle();
        sample(); check("after_rst_busy", busy_mask, 32'h0); check("after_rst_err", 32'(err_spurious), 32'h0);
        advance();

        // Randomized traffic against the model.
        for (int i = 0; i < NREQ; i++) pend_v[i] = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            rst = ($urandom_range(0, 299) == 0);
            issue_valid = 1'($urandom_range(0, 1));
            issue_rs1 = 5'($urandom_range(0, 11));
            issue_rs2 = 5'($urandom_range(0, 11));
            issue_rd  = 5'($urandom_range(0, 11));
            issue_wr  = 1'($urandom_range(0, 1));
            for (int i = 0; i < NREQ; i++) begin
                if (!pend_v[i] && $urandom_range(0, 2) == 0) begin
                    for (int t = 0; t < 8 && !pend_v[i]; t++) begin
                        bit [4:0] r = 5'($urandom_range(1, 11));
                        if (m_busy[r] && !targeted(r)) begin
                            pend_v[i] = 1; pend_rd[i] = r;
                        end
                    end
                    if (!pend_v[i] && $urandom_range(0, 7) == 0) begin
                        pend_v[i] = 1; pend_rd[i] = 5'($urandom_range(0, 31));
                    end
                    pend_data[i] = $urandom;
                end
                req_valid[i] = pend_v[i];
                req_rd[5*i +: 5] = pend_rd[i];
                req_data[XLEN*i +: XLEN] = pend_data[i];
            end
            sample();
            advance();
            for (int i = 0; i < NREQ; i++) if (m_ready[i]) pend_v[i] = 0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
